// File: rtl/sample_word_packer.sv
// Packs four 8-bit ADC samples into 32-bit words and buffers them in a
// first-word-fall-through FIFO whose head word is presented with a ready flag.
module sample_word_packer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SAMPLE_WIDTH-1:0]   sample_in,
  input  logic                      sample_valid,
  input  logic                      frame_start,
  input  logic                      word_ack,
  input  logic                      clear_overflow,
  output logic [4*SAMPLE_WIDTH-1:0] word_data,
  output logic                      word_ready,
  output logic [ADDR_WIDTH:0]       fifo_level,
  output logic [1:0]                lane_count,
  output logic                      overflow
);

  localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [3*SAMPLE_WIDTH-1:0] partial;
  logic [4*SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [4*SAMPLE_WIDTH-1:0] last_word;
  logic [4*SAMPLE_WIDTH-1:0] completed_word;
  logic [ADDR_WIDTH-1:0]     rd_ptr;
  logic [ADDR_WIDTH-1:0]     wr_ptr;
  logic                      push;
  logic                      pop;
  logic                      push_ok;
  logic                      drop;
  logic                      full;
  logic                      empty;

  assign empty          = (fifo_level == '0);
  assign full           = (fifo_level == FULL_LEVEL);
  assign completed_word = {sample_in, partial};
  assign push           = sample_valid && !frame_start && (lane_count == 2'd3);
  assign pop            = word_ack && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok        = push && (!full || pop);
  assign drop           = push && full && !pop;

  assign word_ready = !empty;
  assign word_data  = empty ? last_word : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_count <= 2'd0;
      partial    <= '0;
    end else if (frame_start) begin
      partial <= '0;
      if (sample_valid) begin
        partial[SAMPLE_WIDTH-1:0] <= sample_in;
        lane_count                <= 2'd1;
      end else begin
        lane_count <= 2'd0;
      end
    end else if (sample_valid) begin
      case (lane_count)
        2'd0: partial[SAMPLE_WIDTH-1:0]              <= sample_in;
        2'd1: partial[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]   <= sample_in;
        2'd2: partial[3*SAMPLE_WIDTH-1:2*SAMPLE_WIDTH] <= sample_in;
        default: ;
      endcase
      lane_count <= lane_count + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= completed_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      last_word  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        last_word <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
        2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_word_packer.sv
// Directed, table-driven bench for sample_word_packer with hand-written
// sequences for overflow, full-FIFO push/pop and mid-frame reset.
module tb_sample_word_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  sample_in;
  logic        sample_valid;
  logic        frame_start;
  logic        word_ack;
  logic        clear_overflow;
  logic [31:0] word_data;
  logic        word_ready;
  logic [3:0]  fifo_level;
  logic [1:0]  lane_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [7:0]  sample;
    logic        fs;
    logic        ack;
    logic        clr;
    logic        exp_ready;
    logic [31:0] exp_data;
    logic [3:0]  exp_level;
    logic [1:0]  exp_lane;
    logic        exp_ov;
  } vector_t;

  vector_t vecs[$];

  sample_word_packer #(
    .SAMPLE_WIDTH(8),
    .FIFO_DEPTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .frame_start(frame_start),
    .word_ack(word_ack),
    .clear_overflow(clear_overflow),
    .word_data(word_data),
    .word_ready(word_ready),
    .fifo_level(fifo_level),
    .lane_count(lane_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] s, input logic fs,
                               input logic ack, input logic clr);
    @(negedge clk);
    sample_valid   = v;
    sample_in      = s;
    frame_start    = fs;
    word_ack       = ack;
    clear_overflow = clr;
    @(posedge clk);
    #1;
    sample_valid   = 1'b0;
    sample_in      = 8'h00;
    frame_start    = 1'b0;
    word_ack       = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic rdy, input logic [31:0] data,
                          input logic [3:0] lvl, input logic [1:0] lane, input logic ov);
    checkOutput({name, ".word_ready"}, {31'd0, word_ready}, {31'd0, rdy});
    checkOutput({name, ".word_data"}, word_data, data);
    checkOutput({name, ".fifo_level"}, {28'd0, fifo_level}, {28'd0, lvl});
    checkOutput({name, ".lane_count"}, {30'd0, lane_count}, {30'd0, lane});
    checkOutput({name, ".overflow"}, {31'd0, overflow}, {31'd0, ov});
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic sendSample(input logic [7:0] s);
    applyStimulus(1'b1, s, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_word;

    reset          = 1'b1;
    sample_in      = 8'h00;
    sample_valid   = 1'b0;
    frame_start    = 1'b0;
    word_ack       = 1'b0;
    clear_overflow = 1'b0;

    // Basic packing, held head word, acks, frame realignment.
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 2'd3, 1'b0});
    vecs.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'd1, 2'd0, 1'b0});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 4'd1, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44332211, 4'd0, 2'd0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44332211, 4'd0, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'd0, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'd0, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'd0, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'd0, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44332211, 4'd0, 2'd3, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'd1, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'd1, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'd1, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'd1, 2'd3, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'd1, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04030201, 4'd1, 2'd1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h04030201, 4'd0, 2'd1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h04030201, 4'd0, 2'd1, 1'b0});

    @(posedge clk);
    #1;
    reset = 1'b0;
    checkAll("reset", 1'b0, 32'h0, 4'd0, 2'd0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].sample, vecs[i].fs, vecs[i].ack, vecs[i].clr);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_data,
               vecs[i].exp_level, vecs[i].exp_lane, vecs[i].exp_ov);
    end

    // Overflow: nine words into an 8-deep FIFO; clear on the dropping edge loses to set.
    doReset();
    for (int i = 0; i < 36; i++)
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, (i == 35) ? 1'b1 : 1'b0);
    checkAll("ovf_full", 1'b1, 32'h03020100, 4'd8, 2'd0, 1'b1);
    for (int w = 0; w < 8; w++) begin
      exp_word = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      checkOutput($sformatf("ovf_pop%0d", w), word_data, exp_word);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checkAll("ovf_drained", 1'b0, 32'h1F1E1D1C, 4'd0, 2'd0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO: completing push and pop on the same edge keeps level at 8.
    for (int i = 0; i < 32; i++)
      sendSample(8'(8'h40 + i));
    checkAll("refill", 1'b1, 32'h43424140, 4'd8, 2'd0, 1'b0);
    sendSample(8'h80);
    sendSample(8'h81);
    sendSample(8'h82);
    applyStimulus(1'b1, 8'h83, 1'b0, 1'b1, 1'b0);
    checkAll("full_pushpop", 1'b1, 32'h47464544, 4'd8, 2'd0, 1'b0);
    for (int w = 1; w < 9; w++) begin
      exp_word = (w == 8) ? 32'h83828180 :
                 {8'(8'h43 + 4*w), 8'(8'h42 + 4*w), 8'(8'h41 + 4*w), 8'(8'h40 + 4*w)};
      checkOutput($sformatf("full_pop%0d", w), word_data, exp_word);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("full_empty_level", {28'd0, fifo_level}, 32'd0);

    // Reset mid-frame with three buffered words and two pending lanes.
    doReset();
    for (int i = 0; i < 14; i++)
      sendSample(8'(8'h60 + i));
    checkAll("pre_reset", 1'b1, 32'h63626160, 4'd3, 2'd2, 1'b0);
    doReset();
    checkAll("mid_reset", 1'b0, 32'h0, 4'd0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      sendSample(8'h55);
    checkAll("post_reset", 1'b1, 32'h55555555, 4'd1, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_word_packer.md
Name: sample_word_packer

Overview:
Upstream stage of the AXI-Stream master. Accepts 8-bit hydrophone ADC samples one at a time and packs four consecutive samples into one 32-bit word. Buffers the packed words in a small first-word-fall-through FIFO. Presents the head word with a ready flag (wired to the master's Fourth_Sample_Ready and Input_Data), which stays stable until the consumer acknowledges it.

Parameters:
SAMPLE_WIDTH, 8, bits per ADC sample; fixed at 8 so that 4 lanes make a 32-bit word.
FIFO_DEPTH, 8, number of 32-bit words buffered; must be a power of 2, at least 2.
ADDR_WIDTH, 3, log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
sample_in  input  8  ADC sample, unsigned.
sample_valid  input  1  sample_in is valid this cycle.
frame_start  input  1  realign: discard any partial word; the next sample goes to lane 0.
word_ack  input  1  consumer has taken the head word (pop).
clear_overflow  input  1  clears the sticky overflow flag.
word_data  output  32  head-of-FIFO word; lane k occupies bits [8k+7:8k].
word_ready  output  1  FIFO non-empty (drives Fourth_Sample_Ready).
fifo_level  output  ADDR_WIDTH+1  number of words stored, 0..FIFO_DEPTH.
lane_count  output  2  number of samples held in the partial word, 0..3.
overflow  output  1  sticky flag: a completed word was dropped because the FIFO was full.

Behaviour:
- One clock, synchronous active-high reset. While reset=1 at a rising edge:
  - lane_count=0, partial register=0.
  - FIFO pointers=0, fifo_level=0, word_ready=0, word_data=0.
  - overflow=0.
  - Reset mid-frame drops the partial word and all buffered words, with no residue.
- Packing:
  - sample_valid=1 with lane_count=k<3: store sample_in in lane k; lane_count becomes k+1.
  - sample_valid=1 with lane_count=3: the completed word {sample_in, lane2, lane1, lane0} is pushed at that edge; lane_count wraps to 0.
- frame_start:
  - frame_start=1 resets lane_count to 0 and discards the partial lanes. No push happens, even if lane_count=3.
  - If sample_valid=1 in the same cycle, that sample is written to lane 0 and lane_count becomes 1.
  - frame_start has priority over the normal lane advance.
- Latency: the 4th sample's edge writes the FIFO. word_ready=1 and word_data hold that word from the next cycle when the FIFO was empty (1-cycle latency).
- FIFO is first-word-fall-through:
  - word_data always shows the head word; it is held stable while word_ready=1 and word_ack=0.
  - With an empty FIFO, word_data holds the last popped value, or 0 after reset.
- Pop: word_ack=1 with word_ready=1 advances the head at the edge. word_ack with an empty FIFO is ignored; no pointer move, no underflow.
- Push and pop in the same cycle:
  - Both occur and fifo_level is unchanged, including when the FIFO is full, because the pop frees the slot.
  - When empty, a simultaneous push and pop is impossible since word_ack is ignored; the push lands.
- Overflow:
  - A push with fifo_level=FIFO_DEPTH and no pop drops the new word. FIFO contents are unchanged; overflow is set from the next cycle.
  - lane_count still wraps to 0.
  - overflow stays set until clear_overflow=1 or reset. If set and clear occur in the same cycle, set wins.
- Pointers are ADDR_WIDTH bits and wrap modulo FIFO_DEPTH. fifo_level is tracked explicitly, so full and empty are unambiguous.
- Arithmetic: no sign extension; samples are placed verbatim.

Test Plan:
- Reset, then samples 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> next cycle word_ready=1, word_data=0x44332211, fifo_level=1, lane_count=0.
- Hold word_ack=0 for 10 cycles after the above, then pulse word_ack -> word_data stays 0x44332211 throughout; next cycle word_ready=0, fifo_level=0.
- Feed 36 samples 0x00..0x23 with no acks (9 words, FIFO_DEPTH=8) -> fifo_level=8, overflow=1, 9th word 0x23222120 absent; popping 8 times returns 0x03020100 .. 0x1F1E1D1C in order.
- With FIFO full, the 4th sample of a word and word_ack land on the same edge -> fifo_level stays 8, overflow stays 0, and the new word appears last.
- Samples 0xAA,0xBB, then frame_start with sample_valid on sample 0x01, then 0x02,0x03,0x04 -> the only word pushed is 0x04030201; lane_count=1 right after frame_start.
- Reset asserted with lane_count=2 and fifo_level=3 -> next cycle every output is 0; samples 0x55 x4 then give 0x55555555.
